// File: rtl/abc_pattern_seq_if.sv
// Bundle of the abc_pattern_seq control and pattern signals.
// The loop_mode signal exists only when ABC_SEQ_LOOP_EN is defined.
// master: stimulus side (drives start/abort), slave: the sequencer.
interface abc_pattern_seq_if;
  logic       start;
  logic       abort;
`ifdef ABC_SEQ_LOOP_EN
  logic       loop_mode;
`endif
  logic       a;
  logic       b;
  logic       c;
  logic [1:0] step_idx;
  logic       step_strobe;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output abort,
`ifdef ABC_SEQ_LOOP_EN
    output loop_mode,
`endif
    input  a,
    input  b,
    input  c,
    input  step_idx,
    input  step_strobe,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  abort,
`ifdef ABC_SEQ_LOOP_EN
    input  loop_mode,
`endif
    output a,
    output b,
    output c,
    output step_idx,
    output step_strobe,
    output busy,
    output done
  );
endinterface

// File: rtl/abc_pattern_seq.sv
// abc_pattern_seq: steps the a/b/c inputs of cont_assign through a fixed
// four-entry pattern table, holding each entry HOLD_CYCLES clocks, then
// pulses done. Optional continuous looping is enabled by defining
// ABC_SEQ_LOOP_EN (adds loop_mode to the interface).
module abc_pattern_seq #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [2:0]  P0          = 3'b000,
  parameter logic [2:0]  P1          = 3'b011,
  parameter logic [2:0]  P2          = 3'b101,
  parameter logic [2:0]  P3          = 3'b010
) (
  input logic              clk,
  input logic              rst,
  abc_pattern_seq_if.slave bus
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [2:0]    abc_q;
  logic [1:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic          strobe_q;
  logic          busy_q;
  logic          done_q;
  logic          loop_en;

`ifdef ABC_SEQ_LOOP_EN
  assign loop_en = bus.loop_mode;
`else
  assign loop_en = 1'b0;
`endif

  function automatic logic [2:0] pattern(input logic [1:0] i);
    case (i)
      2'd0:    pattern = P0;
      2'd1:    pattern = P1;
      2'd2:    pattern = P2;
      default: pattern = P3;
    endcase
  endfunction

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      abc_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        // DONE behaves as IDLE for one cycle so a held start chains runs
        IDLE, DONE: begin
          done_q   <= 1'b0;
          strobe_q <= 1'b0;
          busy_q   <= 1'b0;
          state    <= IDLE;
          if (bus.start) begin
            state    <= RUN;
            abc_q    <= P0;
            idx_q    <= '0;
            cnt_q    <= RELOAD;
            strobe_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state    <= IDLE;
            abc_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q    <= cnt_q - 1'b1;
            strobe_q <= 1'b0;
          end else if (idx_q != 2'd3) begin
            idx_q    <= idx_q + 2'd1;
            abc_q    <= pattern(idx_q + 2'd1);
            cnt_q    <= RELOAD;
            strobe_q <= 1'b1;
          end else if (loop_en) begin
            idx_q    <= '0;
            abc_q    <= P0;
            cnt_q    <= RELOAD;
            strobe_q <= 1'b1;
          end else begin
            // abc and step_idx keep the last step
            state    <= DONE;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          abc_q    <= '0;
          idx_q    <= '0;
          cnt_q    <= '0;
          strobe_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a           = abc_q[2];
  assign bus.b           = abc_q[1];
  assign bus.c           = abc_q[0];
  assign bus.step_idx    = idx_q;
  assign bus.step_strobe = strobe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_abc_pattern_seq.sv
// Testbench for abc_pattern_seq: two instances (HOLD_CYCLES=10 with default
// patterns, HOLD_CYCLES=1 with custom patterns) share one stimulus stream.
// A run-time-based reference model predicts every output each cycle.
module tb_abc_pattern_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic lm = 1'b0;

  always #5 clk = ~clk;

  abc_pattern_seq_if bus0 ();
  abc_pattern_seq_if bus1 ();

  assign bus0.start = start;
  assign bus0.abort = abort;
  assign bus1.start = start;
  assign bus1.abort = abort;
`ifdef ABC_SEQ_LOOP_EN
  assign bus0.loop_mode = lm;
  assign bus1.loop_mode = lm;
`endif

  abc_pattern_seq #(.HOLD_CYCLES(10)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  abc_pattern_seq #(
    .HOLD_CYCLES(1),
    .P0(3'b111),
    .P1(3'b100),
    .P2(3'b001),
    .P3(3'b110)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // Gather DUT outputs into arrays so the checker can loop over instances
  logic [2:0] o_abc[2];
  logic [1:0] o_idx[2];
  logic       o_str[2];
  logic       o_busy[2];
  logic       o_done[2];
  assign o_abc[0]  = {bus0.a, bus0.b, bus0.c};
  assign o_abc[1]  = {bus1.a, bus1.b, bus1.c};
  assign o_idx[0]  = bus0.step_idx;
  assign o_idx[1]  = bus1.step_idx;
  assign o_str[0]  = bus0.step_strobe;
  assign o_str[1]  = bus1.step_strobe;
  assign o_busy[0] = bus0.busy;
  assign o_busy[1] = bus1.busy;
  assign o_done[0] = bus0.done;
  assign o_done[1] = bus1.done;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] t=%0t: got %0h, expected %0h", nm, d, $time, act, exp);
    end
  endtask

  // Reference model: a run is described only by elapsed cycles t since start
  int unsigned hold[2];
  logic [2:0]  pat[2][4];
  bit          mvalid = 1'b0;
  bit          running[2];
  int unsigned t[2];
  logic [2:0]  m_abc[2];
  logic [1:0]  m_idx[2];
  bit          m_str[2];
  bit          m_busy[2];
  bit          m_done[2];

  initial begin
    hold[0] = 10;
    hold[1] = 1;
    pat[0][0] = 3'b000; pat[0][1] = 3'b011; pat[0][2] = 3'b101; pat[0][3] = 3'b010;
    pat[1][0] = 3'b111; pat[1][1] = 3'b100; pat[1][2] = 3'b001; pat[1][3] = 3'b110;
  end

  task automatic run_outputs(input int d);
    m_idx[d]  = 2'(t[d] / hold[d]);
    m_abc[d]  = pat[d][t[d] / hold[d]];
    m_str[d]  = (t[d] % hold[d]) == 0;
    m_busy[d] = 1'b1;
    m_done[d] = 1'b0;
  endtask

  task automatic model_step(input int d, input bit loop_eff);
    if (rst) begin
      running[d] = 1'b0;
      t[d] = 0;
      m_abc[d] = '0; m_idx[d] = '0;
      m_str[d] = 1'b0; m_busy[d] = 1'b0; m_done[d] = 1'b0;
    end else if (running[d] && abort) begin
      running[d] = 1'b0;
      m_abc[d] = '0; m_idx[d] = '0;
      m_str[d] = 1'b0; m_busy[d] = 1'b0; m_done[d] = 1'b0;
    end else if (running[d]) begin
      t[d]++;
      if (t[d] == 4 * hold[d]) begin
        if (loop_eff) begin
          t[d] = 0;
          run_outputs(d);
        end else begin
          running[d] = 1'b0;
          m_str[d] = 1'b0; m_busy[d] = 1'b0; m_done[d] = 1'b1;
        end
      end else begin
        run_outputs(d);
      end
    end else if (start) begin
      running[d] = 1'b1;
      t[d] = 0;
      run_outputs(d);
    end else begin
      m_str[d] = 1'b0;
      m_done[d] = 1'b0;
    end
  endtask

  // Advance the model with the inputs sampled at the last posedge, then compare
  initial begin
    bit loop_eff;
    forever begin
      @(negedge clk);
`ifdef ABC_SEQ_LOOP_EN
      loop_eff = lm;
`else
      loop_eff = 1'b0;
`endif
      if (rst) mvalid = 1'b1;
      for (int d = 0; d < 2; d++) begin
        model_step(d, loop_eff);
        if (mvalid) begin
          chk("abc",         d, 32'(o_abc[d]),  32'(m_abc[d]));
          chk("step_idx",    d, 32'(o_idx[d]),  32'(m_idx[d]));
          chk("step_strobe", d, 32'(o_str[d]),  32'(m_str[d]));
          chk("busy",        d, 32'(o_busy[d]), 32'(m_busy[d]));
          chk("done",        d, 32'(o_done[d]), 32'(m_done[d]));
        end
      end
    end
  end

  // Set inputs just after a negedge so they are stable for the next posedge
  task automatic drive(input logic s, input logic a, input logic r);
    @(negedge clk);
    #1;
    start = s;
    abort = a;
    rst   = r;
  endtask

  // Directed scenario; k counts posedges since the start was sampled
  task automatic scenario(input int sc);
    drive(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      case (sc)
        0, 1: begin
          if (k == 0)  begin chk("lit_s0_strobe", 0, 32'(bus0.step_strobe), 1); chk("lit_s0_busy", 0, 32'(bus0.busy), 1); end
          if (k == 9)  begin chk("lit_hold_abc", 0, 32'(o_abc[0]), 32'h0); chk("lit_hold_strobe", 0, 32'(bus0.step_strobe), 0); end
          if (k == 10) begin chk("lit_s1_abc", 0, 32'(o_abc[0]), 32'h3); chk("lit_s1_idx", 0, 32'(bus0.step_idx), 1); end
          if (k == 25) chk("lit_s2_abc", 0, 32'(o_abc[0]), 32'h5);
          if (k == 30) begin chk("lit_s3_abc", 0, 32'(o_abc[0]), 32'h2); chk("lit_s3_strobe", 0, 32'(bus0.step_strobe), 1); end
          if (k == 39) begin chk("lit_last_busy", 0, 32'(bus0.busy), 1); chk("lit_last_done", 0, 32'(bus0.done), 0); end
          if (k == 40) begin chk("lit_done", 0, 32'(bus0.done), 1); chk("lit_done_busy", 0, 32'(bus0.busy), 0); chk("lit_done_abc", 0, 32'(o_abc[0]), 32'h2); end
          if (k == 41) begin chk("lit_post_done", 0, 32'(bus0.done), 0); chk("lit_post_abc", 0, 32'(o_abc[0]), 32'h2); end
        end
        2: begin
          if (k == 15) begin chk("lit_abort_abc", 0, 32'(o_abc[0]), 32'h0); chk("lit_abort_busy", 0, 32'(bus0.busy), 0); chk("lit_abort_idx", 0, 32'(bus0.step_idx), 0); end
          if (k == 20) begin chk("lit_restart_strobe", 0, 32'(bus0.step_strobe), 1); chk("lit_restart_busy", 0, 32'(bus0.busy), 1); end
          if (k == 30) chk("lit_restart_s1", 0, 32'(o_abc[0]), 32'h3);
        end
        3: begin
          if (k == 21) chk("lit_pre_rst_abc", 0, 32'(o_abc[0]), 32'h5);
          if (k == 22) begin chk("lit_rst_abc", 0, 32'(o_abc[0]), 32'h0); chk("lit_rst_busy", 0, 32'(bus0.busy), 0); end
          if (k == 40) chk("lit_rst_nodone", 0, 32'(bus0.done), 0);
        end
        4: begin
          if (k == 41) begin chk("lit_b2b_strobe", 0, 32'(bus0.step_strobe), 1); chk("lit_b2b_busy", 0, 32'(bus0.busy), 1); chk("lit_b2b_done", 0, 32'(bus0.done), 0); end
        end
        default: begin
          if (k == 4) begin chk("lit_loop_abc", 1, 32'(o_abc[1]), 32'h7); chk("lit_loop_busy", 1, 32'(bus1.busy), 1); end
          if (k == 8) begin chk("lit_loop_done", 1, 32'(bus1.done), 1); chk("lit_loop_abc3", 1, 32'(o_abc[1]), 32'h6); end
          if (k == 9) chk("lit_loop_done_end", 1, 32'(bus1.done), 0);
        end
      endcase
      #1;
      start = ((sc == 1) && (k == 4 || k == 24)) || ((sc == 2) && (k == 19)) || ((sc == 4) && (k == 40));
      abort = (sc == 2) && (k == 14);
      rst   = (sc == 3) && (k == 21);
      if (sc == 5 && k == 7) lm = 1'b0;
    end
    repeat (50) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Stimulus: reset, idle, directed scenarios, then random traffic
  initial begin
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    repeat (20) drive(1'b0, 1'b0, 1'b0);
    chk("lit_idle_abc",  0, 32'(o_abc[0]), 32'h0);
    chk("lit_idle_busy", 1, 32'(bus1.busy), 0);
    for (int sc = 0; sc < 5; sc++) scenario(sc);
`ifdef ABC_SEQ_LOOP_EN
    lm = 1'b1;
    scenario(5);
`endif
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      start = ($urandom % 8) == 0;
      abort = ($urandom % 40) == 0;
      rst   = ($urandom % 300) == 0;
      if (($urandom % 32) == 0) lm = ~lm;
    end
    drive(1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
